pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the fetch stage of the pipelined core. It holds the fetch address and advances it sequentially. It applies redirects from EX (mispredict flush) and ID (jump, optional return prediction), and freezes on stall or hazard. A flush that arrives during a memory stall is buffered rather than lost.

## Interface
Parameters:
- ADDR_W, 32, width of the program counter
- RESET_PC, 0, fetch address after reset
- INSTR_BYTES, 4, sequential increment; power of two
- RAS_DEPTH, 4, return-address-stack entries (used only with PC_GEN_RAS_EN)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  run enable
- stall_i  in  1  memory stall; freezes PC, no redirect applied
- hazard_i  in  1  load-use hazard; freezes PC unless flush_i
- flush_i  in  1  EX mispredict redirect
- flush_pc_i  in  ADDR_W  flush target
- jump_i  in  1  ID jump/call redirect
- jump_pc_i  in  ADDR_W  jump target
- call_i  in  1  qualifies jump_i as call; push link_pc_i
- link_pc_i  in  ADDR_W  return address pushed on call
- ret_i  in  1  ID return; redirect to predicted return address
- pc_o  out  ADDR_W  current fetch address
- valid_o  out  1  pc_o is a live fetch request
- pend_o  out  1  buffered flush waiting for stall release

## Operation
- States: IDLE, RUN, PEND.
- Reset: state IDLE, pc_o=RESET_PC, valid_o=0, pend_o=0, pending register 0, RAS count 0.
- IDLE: pc_o held, valid_o=0. start_i=1 moves to RUN with pc_o unchanged, so the first fetch is at RESET_PC.
- RUN with start_i=0: go to IDLE, pc_o held.
- RUN next-PC priority, highest first:
  1. stall_i=1 and flush_i=1: capture flush_pc_i into the pending register, go to PEND, pc_o held.
  2. stall_i=1: hold.
  3. flush_i=1: pc_o=flush_pc_i. Overrides hazard_i.
  4. hazard_i=1: hold.
  5. jump_i=1: pc_o=jump_pc_i.
  6. ret_i=1 and the RAS is non-empty (macro builds only): pc_o=RAS top.
  7. Otherwise pc_o=pc_o+INSTR_BYTES.
- PEND:
  - A new flush_i overwrites the pending target.
  - When stall_i=0: pc_o=pending target, pend_o=0, go to RUN.
  - jump_i, ret_i, call_i, hazard_i and start_i are ignored.
- Redirect targets (flush, jump, ret) have the low log2(INSTR_BYTES) bits forced to 0.
- Increment is modulo 2^ADDR_W: the address 2^ADDR_W-INSTR_BYTES wraps to 0 without a flag.

## Timing
- Single-cycle: inputs are sampled at the rising edge, and pc_o, valid_o and pend_o update at that same edge. There is no combinational path from inputs to outputs.
- A flush accepted in cycle N appears on pc_o after edge N.
- A flush buffered while stalled appears on pc_o one edge after stall_i falls.
- rst_i low mid-operation forces reset values immediately and discards pending state and RAS contents.
- valid_o=1 in RUN and PEND.

## Configuration
- PC_GEN_RAS_EN defined: a RAS_DEPTH circular return-address stack is built.
  - Push of link_pc_i happens when jump_i and call_i are both accepted (priority 5 taken).
  - Pop happens when the priority-6 ret is taken.
  - Push when full overwrites the oldest entry; the count saturates at RAS_DEPTH.
  - ret_i when empty: no pop, sequential increment.
  - A jump with ret_i set (call_i=0) neither pops nor pushes.
  - Flush does not repair RAS contents.
- PC_GEN_RAS_EN undefined: no RAS storage. call_i, link_pc_i and ret_i are ignored, and ret_i falls through to sequential increment. Ports remain present in both builds.

## Test plan
- Reset, hold start_i=0 for 3 cycles, then start_i=1 -> pc_o stays 0 and valid_o=0 while start_i=0; after start, pc_o runs 0x0, 0x4, 0x8, 0xC.
- RUN at 0x10, stall_i=1 for 3 cycles with flush_i=1 (flush_pc_i=0x200) in the 2nd stall cycle -> pc_o holds 0x10 and pend_o=1; after stall_i falls, pc_o=0x200, then 0x204.
- hazard_i=1 together with flush_i=1 (flush_pc_i=0x80) -> pc_o=0x80. hazard_i together with jump_i (jump_pc_i=0x90) -> pc_o holds.
- ADDR_W=8, pc_o=0xFC, no redirect -> next pc_o=0x00. Jump target 0x43 -> pc_o=0x40.
- With PC_GEN_RAS_EN and RAS_DEPTH=2: calls with link_pc_i 0x100, 0x200, 0x300 -> successive ret_i redirect to 0x300, then 0x200. A third ret_i falls through to pc_o+4.
- Without PC_GEN_RAS_EN: call with link_pc_i=0x100, then ret_i at pc_o=0x40 -> next pc_o=0x44.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with stall/hazard freeze, flush
// buffering across memory stalls and an optional return-address stack (PC_GEN_RAS_EN).
module pc_gen #(
    parameter int unsigned          ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
    parameter int unsigned          INSTR_BYTES = 4,
    parameter int unsigned          RAS_DEPTH   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              hazard_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_pc_i,
    input  logic              call_i,
    input  logic [ADDR_W-1:0] link_pc_i,
    input  logic              ret_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              valid_o,
    output logic              pend_o
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] MASK = ~(STEP - ADDR_W'(1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              push, pop;
    logic              ras_hit;
    logic [ADDR_W-1:0] ras_top;

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return a & MASK;
    endfunction

`ifdef PC_GEN_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  top_ptr;
    logic [CNT_W-1:0]  cnt_q;

    // wr_ptr_q is the next free slot; the top sits just below it, circularly
    assign top_ptr = (wr_ptr_q == '0) ? PTR_MAX : wr_ptr_q - PTR_W'(1);
    assign ras_hit = ret_i && (cnt_q != '0);
    assign ras_top = align(ras_q[top_ptr]);

    // stack storage; a push when full simply overwrites the oldest slot
    always_ff @(posedge clk_i) begin
        if (push) begin
            ras_q[wr_ptr_q] <= link_pc_i;
        end
    end

    // stack pointer and occupancy, cleared by reset to discard contents
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (push) begin
            wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
            cnt_q    <= (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (pop) begin
            wr_ptr_q <= top_ptr;
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end
`else
    logic unused_ras;

    assign ras_hit    = 1'b0;
    assign ras_top    = '0;
    assign unused_ras = ^{call_i, link_pc_i, ret_i, push, pop};
`endif

    // next-state and next-PC selection
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        push    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                priority case (1'b1)
                    !start_i: begin
                        state_d = IDLE;
                    end
                    stall_i && flush_i: begin
                        pend_d  = align(flush_pc_i);
                        state_d = PEND;
                    end
                    stall_i: begin
                    end
                    flush_i: begin
                        pc_d = align(flush_pc_i);
                    end
                    hazard_i: begin
                    end
                    jump_i: begin
                        pc_d = align(jump_pc_i);
                        push = call_i;
                    end
                    ras_hit: begin
                        pc_d = ras_top;
                        pop  = 1'b1;
                    end
                    default: begin
                        pc_d = pc_q + STEP;
                    end
                endcase
            end
            PEND: begin
                // the newest flush always wins, even in the release cycle
                if (flush_i) begin
                    pend_d = align(flush_pc_i);
                end
                if (!stall_i) begin
                    pc_d    = flush_i ? align(flush_pc_i) : pend_q;
                    pend_d  = '0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state, PC and pending-target registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    assign pc_o    = pc_q;
    assign valid_o = (state_q != IDLE);
    assign pend_o  = (state_q == PEND);

endmodule
